divider_controller: RTL and testbench

Control FSM that sequences the 10-bit shift/subtract divider datapath. It loads dividend and divisor, runs 14 shift/compare/subtract iterations timed by the datapath's mod-14 counter, and reports completion with error/status flags. It sits between a requester that issues `start` and the datapath's control/status pins. It owns no arithmetic.

---
 rtl/divider_ctl_pkg.sv | 26 ++
 rtl/divider_controller.sv | 154 +++++++++++++++
 tb/tb_divider_controller.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_ctl_pkg.sv
// divider_ctl_pkg
//   Shared definitions for the shift/subtract divider controller:
//   the controller state encoding and the fixed timing constants of one
//   division (iteration count, normal latency, divide-by-zero latency).
package divider_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Shift/compare/subtract iterations per division; equals the datapath
  // counter modulus.
  localparam int DIV_ITERS = 14;

  // Cycles from the edge that samples start to the DONE cycle.
  localparam int DIV_LATENCY = 31;

  // Same measure on the divide-by-zero shortcut path.
  localparam int DIV_DZ_LATENCY = 3;

endpackage

// File: rtl/divider_controller.sv
// divider_controller
//   Control FSM sequencing a 10-bit shift/subtract divider datapath.
//   Loads dividend/divisor, runs ITERS shift+compare iteration pairs timed
//   by the datapath's mod-ITERS counter (co), then pulses done and reports
//   divide-by-zero (dz_err) and quotient overflow (ovf_flag).
//
//   Configuration macro: DIVCTL_ZERO_CHECK_EN
//     defined   : a zero divisor aborts in CHECK, sets dz_err, done after 3 cycles
//     undefined : zero_status ignored, dz_err tied 0, always full 31-cycle run
//
//   Ports
//     clk, clr_n        clock (rising edge), asynchronous active-low reset
//     start             request, only sampled while ready
//     greater           datapath status ACC >= B
//     zero_status       datapath status divisor == 0
//     co                counter carry, high while count == ITERS-1
//     overflow          datapath quotient overflow status
//     load_A, shift_A, load_B            dividend/divisor register controls
//     load_ACC, clear_ACC, shift_ACC     accumulator controls
//     clear_Q, shift_Q, q_serial         quotient controls and serial bit
//     load_c, enable_c                   counter preload / count enable
//     ready, done                        idle indicator, completion pulse
//     dz_err, ovf_flag                   status of the last operation
module divider_controller
  import divider_ctl_pkg::*;
#(
  parameter int ITERS = DIV_ITERS
) (
  input  logic clk,
  input  logic clr_n,
  input  logic start,
  input  logic greater,
  input  logic zero_status,
  input  logic co,
  input  logic overflow,
  output logic load_A,
  output logic shift_A,
  output logic load_B,
  output logic load_ACC,
  output logic clear_ACC,
  output logic shift_ACC,
  output logic clear_Q,
  output logic shift_Q,
  output logic q_serial,
  output logic load_c,
  output logic enable_c,
  output logic ready,
  output logic done,
  output logic dz_err,
  output logic ovf_flag
);

  // The iteration count is set by the datapath counter; this controller
  // only follows co, so any other value indicates a mismatched build.
  if (ITERS != DIV_ITERS) begin : g_iters_mismatch
    $error("divider_controller: ITERS must equal the datapath counter modulus");
  end

  state_e state_q, state_d;

  // Moore outputs are registered from the next state so every control pin
  // comes straight from a flop.
  logic load_q;     // LOAD group: load_A/load_B/clear_ACC/clear_Q/load_c
  logic shift_q;    // SHIFT group: shift_A/shift_ACC
  logic cmp_q;      // COMPARE group: shift_Q/enable_c
  logic ready_q;
  logic done_q;
  logic dz_err_q;
  logic ovf_flag_q;

`ifndef DIVCTL_ZERO_CHECK_EN
  // zero_status has no function in this build.
  logic unused_zero_status;
  assign unused_zero_status = zero_status;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_CHECK;
`ifdef DIVCTL_ZERO_CHECK_EN
      ST_CHECK:   state_d = zero_status ? ST_DONE : ST_SHIFT;
`else
      ST_CHECK:   state_d = ST_SHIFT;
`endif
      ST_SHIFT:   state_d = ST_COMPARE;
      // co is taken in the same cycle enable_c advances the counter, so the
      // last compare is the one that sees count == ITERS-1.
      ST_COMPARE: state_d = co ? ST_DONE : ST_SHIFT;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      load_q     <= 1'b0;
      shift_q    <= 1'b0;
      cmp_q      <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      dz_err_q   <= 1'b0;
      ovf_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= (state_d == ST_LOAD);
      shift_q <= (state_d == ST_SHIFT);
      cmp_q   <= (state_d == ST_COMPARE);
      ready_q <= (state_d == ST_IDLE);
      done_q  <= (state_d == ST_DONE);

      // Status flags describe the last operation; an accepted start wipes them.
      if (state_q == ST_IDLE && start) begin
        dz_err_q   <= 1'b0;
        ovf_flag_q <= 1'b0;
      end

`ifdef DIVCTL_ZERO_CHECK_EN
      if (state_q == ST_CHECK && zero_status) begin
        dz_err_q <= 1'b1;
      end
`else
      dz_err_q <= 1'b0;
`endif

      // The aborted path never ran the datapath, so its overflow is meaningless.
      if (state_q == ST_DONE && !dz_err_q) begin
        ovf_flag_q <= overflow;
      end
    end
  end

  assign load_A    = load_q;
  assign load_B    = load_q;
  assign clear_ACC = load_q;
  assign clear_Q   = load_q;
  assign load_c    = load_q;
  assign shift_A   = shift_q;
  assign shift_ACC = shift_q;
  assign shift_Q   = cmp_q;
  assign enable_c  = cmp_q;

  // Quotient bit and conditional subtract follow greater within COMPARE.
  assign q_serial  = cmp_q & greater;
  assign load_ACC  = cmp_q & greater;

  assign ready     = ready_q;
  assign done      = done_q;
  assign dz_err    = dz_err_q;
  assign ovf_flag  = ovf_flag_q;

endmodule

// File: tb/tb_divider_controller.sv
// tb_divider_controller
//   Drives divider_controller together with a behavioural 10-bit
//   shift/subtract datapath. Stimulus pushes expected results (computed
//   with plain integer division) into a scoreboard queue; a monitor pops
//   and compares on every done pulse.
//   Honours DIVCTL_ZERO_CHECK_EN for the divide-by-zero expectations.
module tb_divider_controller;

  logic clk = 1'b0;
  logic clr_n = 1'b1;
  logic start = 1'b0;
  logic greater, zero_status, co, overflow;
  logic load_A, shift_A, load_B, load_ACC, clear_ACC, shift_ACC;
  logic clear_Q, shift_Q, q_serial, load_c, enable_c;
  logic ready, done, dz_err, ovf_flag;

  always #5 clk = ~clk;

  divider_controller dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .greater    (greater),
    .zero_status(zero_status),
    .co         (co),
    .overflow   (overflow),
    .load_A     (load_A),
    .shift_A    (shift_A),
    .load_B     (load_B),
    .load_ACC   (load_ACC),
    .clear_ACC  (clear_ACC),
    .shift_ACC  (shift_ACC),
    .clear_Q    (clear_Q),
    .shift_Q    (shift_Q),
    .q_serial   (q_serial),
    .load_c     (load_c),
    .enable_c   (enable_c),
    .ready      (ready),
    .done       (done),
    .dz_err     (dz_err),
    .ovf_flag   (ovf_flag)
  );

  // ---------------- behavioural datapath ----------------
  logic [9:0]  a_in = '0, b_in = '0;
  logic [9:0]  a_reg = '0, b_reg = '0, q_reg = '0;
  logic [10:0] acc_reg = '0;
  logic [3:0]  cnt_reg = '0;
  logic        ovf_reg = 1'b0;

  assign greater     = (acc_reg >= {1'b0, b_reg});
  assign zero_status = (b_reg == 10'd0);
  assign co          = (cnt_reg == 4'd13);
  assign overflow    = ovf_reg;

  always @(posedge clk) begin
    if (load_A) a_reg <= a_in;
    else if (shift_A) a_reg <= {a_reg[8:0], 1'b0};
    if (load_B) b_reg <= b_in;
    if (clear_ACC) acc_reg <= '0;
    else if (shift_ACC) acc_reg <= {acc_reg[9:0], a_reg[9]};
    else if (load_ACC) acc_reg <= acc_reg - {1'b0, b_reg};
    if (clear_Q) begin
      q_reg   <= '0;
      ovf_reg <= 1'b0;
    end else if (shift_Q) begin
      q_reg   <= {q_reg[8:0], q_serial};
      ovf_reg <= ovf_reg | q_reg[9];
    end
    if (load_c) cnt_reg <= '0;
    else if (enable_c) cnt_reg <= (cnt_reg == 4'd13) ? 4'd0 : cnt_reg + 4'd1;
  end

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    int a;
    int b;
    int q;
    bit chk_q;
    bit dz;
    bit ovf;
    int lat;
    int pulses;
    int start_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   load_cycs[$];
  int   en_cnt   = 0;
  int   shq_cnt  = 0;
  bit   post_pending = 1'b0;
  exp_t post_exp;

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   qf;
    e.a = a; e.b = b; e.start_cyc = 0;
    if (b == 0) begin
`ifdef DIVCTL_ZERO_CHECK_EN
      e.q = 0; e.chk_q = 1'b0; e.dz = 1'b1; e.ovf = 1'b0; e.lat = 3; e.pulses = 0;
`else
      // ACC >= 0 always holds, so every quotient bit is 1.
      e.q = 1023; e.chk_q = 1'b1; e.dz = 1'b0; e.ovf = 1'b1; e.lat = 31; e.pulses = 14;
`endif
    end else begin
      // 14 iterations over a 10-bit dividend divide A*16; Q keeps 10 bits.
      qf = (a * 16) / b;
      e.q = qf % 1024; e.chk_q = 1'b1; e.dz = 1'b0; e.ovf = (qf >= 1024);
      e.lat = 31; e.pulses = 14;
    end
    return e;
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- monitor ----------------
  initial forever begin
    exp_t cur;
    @(negedge clk);
    if (clr_n) begin
      if (shift_Q) begin
        check("q_serial_cmp", q_serial, greater);
        check("load_ACC_cmp", load_ACC, greater);
      end else begin
        check("q_serial_off", q_serial, 0);
        check("load_ACC_off", load_ACC, 0);
      end
      if (load_A) begin
        en_cnt  = 0;
        shq_cnt = 0;
        load_cycs.push_back(cyc);
      end
      if (enable_c) en_cnt++;
      if (shift_Q) shq_cnt++;
      if (post_pending) begin
        post_pending = 1'b0;
        check("ovf_flag", ovf_flag, post_exp.ovf);
        check("ready_return", ready, 1);
        check("dz_err_hold", dz_err, post_exp.dz);
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          cur = sb.pop_front();
          check("latency", cyc - cur.start_cyc, cur.lat);
          check("dz_err", dz_err, cur.dz);
          if (cur.chk_q) check("quotient", q_reg, cur.q);
          check("enable_c_pulses", en_cnt, cur.pulses);
          check("shift_Q_pulses", shq_cnt, cur.pulses);
          check("ready_in_done", ready, 0);
          $display("op a=%0d b=%0d -> q=%0d dz=%0d lat=%0d (exp q=%0d dz=%0d lat=%0d)",
                   cur.a, cur.b, q_reg, dz_err, cyc - cur.start_cyc, cur.q, cur.dz, cur.lat);
          post_exp     = cur;
          post_pending = 1'b1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check("ready_timeout", ready, 1);
  endtask

  task automatic issue(input int a, input int b);
    exp_t e;
    wait_ready();
    a_in = 10'(a);
    b_in = 10'(b);
    e = model(a, b);
    e.start_cyc = cyc;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || post_pending) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1, e2;
    int   base, t;

    // Reset state
    #1 clr_n = 1'b0;
    #2;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_load_A", load_A, 0);
    check("rst_shift_Q", shift_Q, 0);
    check("rst_dz_err", dz_err, 0);
    check("rst_ovf_flag", ovf_flag, 0);
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(100, 7);
    issue(1023, 1);
    issue(0, 5);
    issue(5, 0);
    issue(1, 1023);
    drain();

    // start held high: one operation per IDLE visit, second LOAD 32 cycles later
    wait_ready();
    a_in = 10'd100;
    b_in = 10'd7;
    e1 = model(100, 7);
    e1.start_cyc = cyc;
    e2 = model(100, 7);
    e2.start_cyc = cyc + e1.lat + 1;
    sb.push_back(e1);
    sb.push_back(e2);
    base = load_cycs.size();
    start = 1'b1;
    t = 0;
    while (load_cycs.size() < base + 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    check("held_start_loads", load_cycs.size(), base + 2);
    if (load_cycs.size() >= base + 2)
      check("second_load_gap", load_cycs[base + 1] - load_cycs[base], e1.lat + 1);
    drain();

    // Held start on a zero divisor
    wait_ready();
    a_in = 10'd9;
    b_in = 10'd0;
    e1 = model(9, 0);
    e1.start_cyc = cyc;
    e2 = model(9, 0);
    e2.start_cyc = cyc + e1.lat + 1;
    sb.push_back(e1);
    sb.push_back(e2);
    base = load_cycs.size();
    start = 1'b1;
    t = 0;
    while (load_cycs.size() < base + 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    check("held_start_loads_dz", load_cycs.size(), base + 2);
    if (load_cycs.size() >= base + 2)
      check("second_load_gap_dz", load_cycs[base + 1] - load_cycs[base], e1.lat + 1);
    drain();

    // Asynchronous reset in the middle of an operation
    issue(100, 7);
    repeat (8) @(negedge clk);
    check("pre_rst_busy", ready, 0);
    #2 clr_n = 1'b0;
    #1;
    check("arst_ready", ready, 1);
    check("arst_done", done, 0);
    check("arst_shift_A", shift_A, 0);
    check("arst_shift_Q", shift_Q, 0);
    check("arst_enable_c", enable_c, 0);
    check("arst_load_ACC", load_ACC, 0);
    check("arst_q_serial", q_serial, 0);
    check("arst_dz_err", dz_err, 0);
    check("arst_ovf_flag", ovf_flag, 0);
    sb.delete();
    post_pending = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    issue(100, 7);
    drain();

    // Randomised operations
    for (int i = 0; i < 30; i++) begin
      int a, b;
      a = int'($urandom_range(0, 1023));
      case ($urandom_range(0, 7))
        0:       b = 0;
        1, 2:    b = int'($urandom_range(1, 15));
        default: b = int'($urandom_range(1, 1023));
      endcase
      issue(a, b);
    end
    drain();

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
